// File: rtl/xs3g_scan_ctrl.sv
// xs3g_scan_ctrl
// Multiplexed display scan controller. Four host-written BCD digit registers
// are scanned one at a time onto a single shared excess-3-Gray decoder
// (LS44-type). Each slot lasts PRESCALE clocks, and its first BLANK clocks
// are dark. Leading-zero blanking can suppress the upper digits.
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous reset, active-high
//   en       scan enable; 0 freezes counters, latch and outputs
//   wr       digit register write strobe
//   waddr    digit index to write (0 = least significant)
//   wdata    BCD value to write; values above 9 are rejected and set err
//   lzb      leading-zero blanking enable
//   clr_err  clears err (a same-cycle invalid write wins)
//   code     decoder inputs {D,C,B,A}; 0000 turns every decoder output off
//   strobe   one-hot digit enable, active-high
//   frame    one-cycle pulse on the last clock of a full 4-digit scan
//   err      sticky invalid-write flag
//
// The scan has no separate FSM. cnt/idx are the state, and the scan
// sequence is slot 0 -> 1 -> 2 -> 3 -> 0. Each slot is split into a blank
// part (cnt < BLANK) and a lit part.
//
// state  | meaning
// blank  | cnt < BLANK or digit suppressed: code=0000, strobe=0000
// lit    | strobe[idx]=1, code=xs3g(latched digit)

module xs3g_scan_ctrl #(
  parameter int PRESCALE = 16,
  parameter int BLANK    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       wr,
  input  logic [1:0] waddr,
  input  logic [3:0] wdata,
  input  logic       lzb,
  input  logic       clr_err,
  output logic [3:0] code,
  output logic [3:0] strobe,
  output logic       frame,
  output logic       err
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);

  logic [3:0]    dig [4];
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    idx, idx_nxt;
  logic [3:0]    latch, latch_nxt;
  logic          supp, supp_nxt;
  logic          slot_end, blank_nxt, frame_q;
  logic [3:0]    upper_zero;

  function automatic logic [3:0] xs3g(input logic [3:0] n);
    logic [3:0] x;
    x = n + 4'd3;
    return x ^ (x >> 1);
  endfunction

  // The outputs are registered against the cnt/idx/latch values that become
  // current at the same edge. All of that next-state is formed here.
  always_comb begin
    slot_end = (cnt == CNT_MAX);
    cnt_nxt  = slot_end ? '0 : cnt + CW'(1);
    idx_nxt  = slot_end ? idx + 2'd1 : idx;

    // upper_zero[i]: digit i and every higher digit are zero
    upper_zero[3] = (dig[3] == 4'd0);
    for (int i = 2; i >= 0; i--)
      upper_zero[i] = upper_zero[i+1] && (dig[i] == 4'd0);

    // Latch and suppress use the pre-write digit values. A write landing on
    // the slot-start edge therefore shows on that digit's next scan.
    latch_nxt = slot_end ? dig[idx_nxt] : latch;
    supp_nxt  = slot_end ? (lzb && (idx_nxt != 2'd0) && upper_zero[idx_nxt])
                         : supp;
    blank_nxt = (int'(cnt_nxt) < BLANK) || supp_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) dig[i] <= 4'd0;
      cnt     <= '0;
      idx     <= 2'd0;
      latch   <= 4'd0;
      supp    <= 1'b0;
      code    <= 4'd0;
      strobe  <= 4'd0;
      frame_q <= 1'b0;
      err     <= 1'b0;
    end else begin
      if (wr && (wdata <= 4'd9)) dig[waddr] <= wdata;

      if (wr && (wdata > 4'd9)) err <= 1'b1;
      else if (clr_err)         err <= 1'b0;

      if (en) begin
        cnt     <= cnt_nxt;
        idx     <= idx_nxt;
        latch   <= latch_nxt;
        supp    <= supp_nxt;
        code    <= blank_nxt ? 4'd0 : xs3g(latch_nxt);
        strobe  <= blank_nxt ? 4'd0 : (4'b0001 << idx_nxt);
        frame_q <= (cnt_nxt == CNT_MAX) && (idx_nxt == 2'd3);
      end
    end
  end

  // frame_q marks the terminal cycle. Gating it with en keeps the pulse
  // from appearing while the scan is frozen on that cycle.
  assign frame = frame_q & en;

endmodule

// File: tb/tb_xs3g_scan_ctrl.sv
module tb_xs3g_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic       wr = 1'b0;
  logic [1:0] waddr = 2'd0;
  logic [3:0] wdata = 4'd0;
  logic       lzb = 1'b0;
  logic       clr_err = 1'b0;
  logic [3:0] code, strobe;
  logic       frame, err;

  xs3g_scan_ctrl #(.PRESCALE(4), .BLANK(1)) dut (
    .clk(clk), .rst(rst), .en(en), .wr(wr), .waddr(waddr), .wdata(wdata),
    .lzb(lzb), .clr_err(clr_err), .code(code), .strobe(strobe),
    .frame(frame), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    bit         is_err;
    logic [3:0] code;
    logic [3:0] strobe;
    logic       frame;
    logic       err;
    string      tag;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  task automatic push_cs(input int c, input logic [3:0] cd, input logic [3:0] sb,
                         input logic fr, input string tag);
    exp_t e;
    e.cyc = c; e.is_err = 1'b0; e.code = cd; e.strobe = sb; e.frame = fr;
    e.err = 1'b0; e.tag = tag;
    q.push_back(e);
  endtask

  task automatic push_err(input int c, input logic ev, input string tag);
    exp_t e;
    e.cyc = c; e.is_err = 1'b1; e.code = 4'd0; e.strobe = 4'd0; e.frame = 1'b0;
    e.err = ev; e.tag = tag;
    q.push_back(e);
  endtask

  // Expected output for frame-relative cycles k0..k1 (PRESCALE=4, BLANK=1).
  // codes/strobes are packed {slot3,slot2,slot1,slot0}.
  task automatic push_frame(input int base, input logic [15:0] codes,
                            input logic [15:0] strobes, input int k0,
                            input int k1, input string tag);
    for (int k = k0; k <= k1; k++) begin
      int s;
      s = k / 4;
      if (k % 4 == 0) push_cs(base + k, 4'd0, 4'd0, 1'b0, tag);
      else push_cs(base + k, codes[s*4 +: 4], strobes[s*4 +: 4], k == 15, tag);
    end
  endtask

  // Monitor: compares every expectation due in the current cycle.
  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc < cyc) begin
        total++; bad++;
        $display("FAIL %s stale check cyc=%0d now=%0d", q[i].tag, q[i].cyc, cyc);
        q.delete(i);
      end else if (q[i].cyc == cyc) begin
        if (q[i].is_err) begin
          total++;
          if (err !== q[i].err) begin
            bad++;
            $display("FAIL %s err cyc=%0d got=%b exp=%b", q[i].tag, cyc, err, q[i].err);
          end
        end else begin
          total++;
          if (code !== q[i].code) begin
            bad++;
            $display("FAIL %s code cyc=%0d got=%b exp=%b", q[i].tag, cyc, code, q[i].code);
          end
          total++;
          if (strobe !== q[i].strobe) begin
            bad++;
            $display("FAIL %s strobe cyc=%0d got=%b exp=%b", q[i].tag, cyc, strobe, q[i].strobe);
          end
          total++;
          if (frame !== q[i].frame) begin
            bad++;
            $display("FAIL %s frame cyc=%0d got=%b exp=%b", q[i].tag, cyc, frame, q[i].frame);
          end
        end
        q.delete(i);
      end
    end
  end

  // Return just after edge c; inputs set afterwards are sampled at edge c+1.
  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_write(input int edge_c, input logic [1:0] a, input logic [3:0] d,
                          input logic ce);
    wait_cyc(edge_c - 1);
    wr = 1'b1; waddr = a; wdata = d; clr_err = ce;
    wait_cyc(edge_c);
    wr = 1'b0; clr_err = 1'b0;
  endtask

  task automatic do_clr(input int edge_c);
    wait_cyc(edge_c - 1);
    clr_err = 1'b1;
    wait_cyc(edge_c);
    clr_err = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;

    // Reset on edges 1..3; all digits zero in the first frame.
    push_err(3, 1'b0, "rst_err");
    push_frame(3, 16'h2222, 16'h8421, 0, 15, "f1_reset");
    wait_cyc(3);
    rst = 1'b0;

    // Digits 9,4,7,0 are written during frame 1 and shown in frame 2.
    // Frame 3 repeats them, so an invalid write to dig[2] changes nothing.
    push_frame(19, 16'h2F4A, 16'h8421, 0, 15, "f2_digits");
    push_frame(35, 16'h2F4A, 16'h8421, 0, 15, "f3_after_bad");
    push_err(22, 1'b0, "err_pre");
    push_err(23, 1'b1, "err_set");
    push_err(24, 1'b1, "err_sticky");
    push_err(25, 1'b0, "err_clr");
    push_err(27, 1'b1, "err_set_wins");
    push_err(29, 1'b0, "err_clr2");
    do_write(12, 2'd0, 4'd9, 1'b0);
    do_write(13, 2'd1, 4'd4, 1'b0);
    do_write(14, 2'd2, 4'd7, 1'b0);
    do_write(15, 2'd3, 4'd0, 1'b0);
    do_write(23, 2'd2, 4'd12, 1'b0);
    do_clr(25);
    do_write(27, 2'd0, 4'd15, 1'b1);
    do_clr(29);

    // Digits {0,0,5,0}. Frame 4 runs with lzb=1 and frame 5 with lzb=0.
    push_frame(51, 16'h00C2, 16'h0021, 0, 15, "f4_lzb1");
    push_frame(67, 16'h22C2, 16'h8421, 0, 15, "f5_lzb0");
    do_write(48, 2'd0, 4'd0, 1'b0);
    do_write(49, 2'd1, 4'd5, 1'b0);
    do_write(50, 2'd2, 4'd0, 1'b0);
    lzb = 1'b1;
    wait_cyc(63);
    lzb = 1'b0;

    // Frame 6: dig[1]=8 is written on its slot-start edge, and en is held
    // low for 10 edges in slot 2 while dig[0]=3 is written.
    push_frame(83, 16'h22C2, 16'h8421, 0, 9, "f6_pre_hold");
    for (int c = 93; c <= 102; c++) push_cs(c, 4'b0010, 4'b0100, 1'b0, "hold");
    push_frame(93, 16'h22C2, 16'h8421, 10, 15, "f6_resume");
    push_frame(109, 16'h22E5, 16'h8421, 0, 15, "f7_new_digits");
    do_write(87, 2'd1, 4'd8, 1'b0);
    wait_cyc(92);
    en = 1'b0;
    do_write(95, 2'd0, 4'd3, 1'b0);
    wait_cyc(102);
    en = 1'b1;

    // Frame 8: err is set, then reset is applied at idx=2, cnt=2.
    push_frame(125, 16'h22E5, 16'h8421, 0, 10, "f8_pre_rst");
    push_err(134, 1'b1, "err_before_rst");
    push_err(136, 1'b0, "err_after_rst");
    push_frame(136, 16'h2222, 16'h8421, 0, 15, "after_rst");
    do_write(128, 2'd3, 4'd10, 1'b0);
    wait_cyc(135);
    rst = 1'b1;
    wait_cyc(136);
    rst = 1'b0;

    g = 0;
    while (q.size() > 0 && g < 100) begin
      @(posedge clk);
      g++;
    end
    @(posedge clk);
    #1;
    while (q.size() > 0) begin
      total++; bad++;
      $display("FAIL %s never checked cyc=%0d", q[0].tag, q[0].cyc);
      void'(q.pop_front());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xs3g_scan_ctrl.md
Name: xs3g_scan_ctrl

Overview:
- Multiplexed display scan controller that time-shares one excess-3-Gray-to-decimal decoder (LS44-type) between four digit positions.
- Holds four BCD digit registers written by a host.
- Converts the selected digit to excess-3 Gray and drives the shared decoder's D,C,B,A inputs together with a one-hot digit strobe.
- Inserts blanking between slots and supports leading-zero suppression.

Parameters:
- PRESCALE, 16, clocks per digit slot; legal range 2..65535.
- BLANK, 2, clocks at the start of each slot with all outputs off; legal range 0..PRESCALE-1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous reset, active-high.
- en  input  1  scan enable; 0 freezes the scan state.
- wr  input  1  write strobe for a digit register.
- waddr  input  2  digit index to write (0 = least significant).
- wdata  input  4  BCD value to write.
- lzb  input  1  leading-zero blanking enable.
- clr_err  input  1  clears the err flag.
- code  output  4  to the shared decoder: code[3]=D, code[2]=C, code[1]=B, code[0]=A.
- strobe  output  4  one-hot digit enable, active-high.
- frame  output  1  one-cycle pulse at the end of each full 4-digit scan.
- err  output  1  sticky flag: an invalid BCD value was written.

Behaviour:
- Reset (rst=1 at an edge) clears:
  - dig[0..3] to 0, latch to 0, cnt to 0, idx to 0.
  - code to 0000, strobe to 0000, frame to 0, err to 0.
  - Reset overrides every other input, including mid-slot.
- Digit write:
  - wr=1 with wdata<=9: dig[waddr] takes wdata at that edge.
  - wr=1 with wdata>=10: no register change; err is set to 1.
  - err set and clr_err in the same cycle: err ends at 1 (set wins).
- Scan state:
  - cnt counts 0..PRESCALE-1; idx counts 0..3.
  - en=1: cnt increments each edge. When cnt==PRESCALE-1, cnt goes to 0 and idx increments, wrapping 3 to 0.
  - en=0: cnt, idx, latch and all outputs hold. Digit writes and err updates still occur.
- Slot start (the edge where cnt becomes 0, including the first edge after reset):
  - latch <= dig[next idx].
  - suppress <= lzb AND next idx!=0 AND dig[next idx] and every higher-index digit are all 0.
  - If a write hits the same digit on the same edge, the old value is latched. The new value appears on the next scan of that digit.
- Outputs are registered and correspond to the cnt/idx held in the same cycle:
  - cnt<BLANK, or suppress=1: code=0000 (invalid code, so all decoder outputs are high/off) and strobe=0000.
  - Otherwise: strobe bit idx=1 and code=xs3g(latch).
- xs3g(n) = G(n+3), where G(x) = x XOR (x>>1). Values for 0..9: 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010.
- Strobe is never active while code=0000, and never changes in the same cycle as a code change between two valid codes. A blank of at least one cycle separates them when BLANK>=1.
- frame=1 for exactly the one cycle where en=1, cnt==PRESCALE-1 and idx==3. It is 0 otherwise, including while en=0.
- Scan period is 4*PRESCALE enabled clocks. Each digit is lit for PRESCALE-BLANK clocks.

Test Plan:
- Reset, PRESCALE=4, BLANK=1, en=1:
  - Hold rst 3 cycles, release.
  - Required: first cycle code=0000, strobe=0000.
  - Next 3 cycles code=0010 (digit 0 = 0), strobe=0001.
  - Cycle 5 blank; cycle 6 strobe=0010.
  - frame high on cycle 16 only.
- Write digits 9,4,7,0 to waddr 0..3, then scan one frame:
  - Slot 0: code=1010, strobe=0001. Slot 1: 0100, 0010. Slot 2: 1111, 0100. Slot 3: 0010, 1000.
  - strobe=0000 during each blank cycle.
- Invalid write:
  - wr=1, waddr=2, wdata=1100. Required: err=1 next cycle, dig[2] unchanged on its next scan.
  - clr_err pulse: err=0.
  - Bad write plus clr_err in the same cycle: err=1.
- Leading-zero blanking, lzb=1:
  - Digits {3:0, 2:0, 1:5, 0:0}: slots 3 and 2 strobe=0000 with code=0000; slot 1 code=1100; slot 0 code=0010, strobe=0001.
  - Same digits with lzb=0: all four slots strobed.
- Enable hold and same-edge write:
  - en=0 mid-slot for 10 cycles: cnt, code, strobe frozen and frame=0; writes still land.
  - Write dig[1]=8 on the edge where slot 1 starts: old value displayed; 1110 appears one frame later.
- Reset mid-operation:
  - Assert rst while idx=2, cnt=2. Required: next cycle code=0000, strobe=0000, err=0, all digits 0.
  - Scan restarts at idx=0.
